// File: rtl/alu_cmd_sequencer.sv
// Command front end for an 8-bit ALU: a small operand register file plus an
// IDLE/EXEC/RESP sequencer that drives the ALU and returns results over valid/ready.
module alu_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [2:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_rd,
  input  logic [IDX_W-1:0]  cmd_rs1,
  input  logic [IDX_W-1:0]  cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [2:0]        alu_op_o,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [IDX_W-1:0]  rsp_rd,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic [IDX_W-1:0]    rd_q, rd_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [IDX_W-1:0]    rsp_rd_q, rsp_rd_d;

  // Next-state and datapath update; sources are read at acceptance so rd==rs sees the old value
  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rd_d       = rd_q;
    rsp_data_d = rsp_data_q;
    rsp_rd_d   = rsp_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            regs_d[cmd_rd] = cmd_imm;
            rsp_data_d     = cmd_imm;
            rsp_rd_d       = cmd_rd;
            state_d        = ST_RESP;
          end else begin
            alu_a_d  = regs_q[cmd_rs1];
            alu_b_d  = regs_q[cmd_rs2];
            alu_op_d = cmd_op;
            rd_d     = cmd_rd;
            state_d  = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        regs_d[rd_q] = alu_res_i;
        rsp_data_d   = alu_res_i;
        rsp_rd_d     = rd_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, register file and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      alu_a_q    <= {DATA_W{1'b0}};
      alu_b_q    <= {DATA_W{1'b0}};
      alu_op_q   <= 3'b000;
      rd_q       <= {IDX_W{1'b0}};
      rsp_data_q <= {DATA_W{1'b0}};
      rsp_rd_q   <= {IDX_W{1'b0}};
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rd_q       <= rd_d;
      rsp_data_q <= rsp_data_d;
      rsp_rd_q   <= rsp_rd_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy_o    = (state_q != ST_IDLE);
  assign alu_a_o   = alu_a_q;
  assign alu_b_o   = alu_b_q;
  assign alu_op_o  = alu_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven front end for the 8-bit `simple_alu` datapath: accepts register-level commands over a valid/ready channel and holds a small operand register file. For each ALU command it drives the ALU's operand and opcode inputs and captures the combinational result. It writes the result back and returns it over a valid/ready response channel. It is the initiator side of the ALU port contract (`a`, `b`, `op` → result) and sits between a test/control master and one ALU instance.

## Interface
- `DATA_W`, 8, operand/result width; must equal the ALU width.
- `NREGS`, 4, register-file entries; register index width is `$clog2(NREGS)` (2 at default).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: sequencer can accept a command; high only in IDLE.
- `cmd_load` input 1: 1 = load immediate into `cmd_rd`; 0 = ALU command.
- `cmd_op` input 3: ALU opcode (000 ADD, 001 SUB, 010 SLL, 011 LSR, 100 AND, 101 OR, 110 XOR, 111 EQL).
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` input 2 each: destination and source register indices.
- `cmd_imm` input DATA_W: immediate value for a load.
- `alu_a_o`, `alu_b_o` output DATA_W: operands to the ALU.
- `alu_op_o` output 3: opcode to the ALU.
- `alu_res_i` input DATA_W: combinational ALU result.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_data` output DATA_W: written-back value (ALU result or immediate).
- `rsp_rd` output 2: register index written.
- `busy_o` output 1: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid` with `cmd_load` = 1: write `cmd_imm` to `regs[cmd_rd]`; load `rsp_data` = `cmd_imm` and `rsp_rd` = `cmd_rd`; go to RESP. EXEC is skipped.
  - On `cmd_valid` with `cmd_load` = 0: register `alu_a_o` = `regs[cmd_rs1]`, `alu_b_o` = `regs[cmd_rs2]`, `alu_op_o` = `cmd_op`; latch `cmd_rd`; go to EXEC.
- **EXEC** (exactly 1 cycle)
  - The ALU ports are stable for the whole cycle.
  - At the closing edge: sample `alu_res_i` into `regs[rd]` and into `rsp_data`; set `rsp_rd` = rd; go to RESP.
- **RESP**
  - `rsp_valid` = 1; `rsp_data` and `rsp_rd` are held stable until `rsp_valid && rsp_ready`, then the FSM returns to IDLE.
- The result is taken verbatim from the ALU, with no post-processing: an EQL result of 8'h01/8'h00 is stored as-is, and SUB wraps modulo 2^DATA_W.
- Source registers are read at acceptance, so `rd` == `rs1` or `rs2` uses the old value.
- `alu_a_o`, `alu_b_o` and `alu_op_o` hold their last values outside EXEC. Bench checks on these ports apply only during EXEC.
- Commands are never dropped. A command presented while `cmd_ready` = 0 waits upstream.

## Timing
- All outputs reset to 0, all registers reset to 0, and the state resets to IDLE. `cmd_ready` is 1 as soon as `rst_n` is released.
- ALU command accepted at edge T:
  - EXEC runs in cycle T+1.
  - `rsp_valid` rises after edge T+2.
  - The register-file write is visible to a command accepted at T+3 or later.
- Load accepted at edge T: `rsp_valid` rises after edge T+1.
- Maximum throughput with `rsp_ready` held high: 1 ALU command per 3 cycles, 1 load per 2 cycles.
- `cmd_ready` drops in the cycle after acceptance and returns the cycle after the response handshake.
- `rsp_ready` may be high before `rsp_valid`; the handshake then completes in the first RESP cycle.
- Asserting `rst_n` = 0 at any point (e.g. mid-EXEC or mid-RESP) immediately, and asynchronously:
  - clears `rsp_valid` and `busy_o`;
  - zeroes all registers;
  - forces IDLE.
  
  The in-flight response is lost.

## Test plan
- Reset → all outputs 0, `cmd_ready` = 1, reading r0..r3 via ADD with r0 gives 0.
- Load r0 = 0x05 and r1 = 0x03, then ADD r2 = r0 + r1 (behavioural ALU attached):
  - during EXEC: `alu_a_o` = 0x05, `alu_b_o` = 0x03, `alu_op_o` = 000;
  - `rsp_data` = 0x08 with `rsp_rd` = 2, 2 cycles after acceptance.
- SUB r3 = r1 − r0 → 0xFE. Then EQL r2 = r0 == r0 → 0x01, and EQL r2 = r0 == r1 → 0x00.
- SLL with r0 = 0x05 and r1 = 0x0B → `rsp_data` = 0x28. Then ADD r0 = r0 + r0 (same-register source/destination) → old value used, r0 = 0x50.
- Hold `rsp_ready` = 0 for 5 cycles during RESP → `rsp_valid`, `rsp_data` and `rsp_rd` stable, `cmd_ready` = 0. Release → handshake, IDLE on the next cycle.
- Drop `rst_n` during EXEC of an ADD → state IDLE, `rsp_valid` never asserts for that command, and a subsequent ADD r0 + r1 returns 0x00.
